// File: rtl/lf_cmd_pkg.sv
// rtl/lf_cmd_pkg.sv - opcodes, reset defaults and FSM states shared by the LF SPI command receiver
package lf_cmd_pkg;

  localparam logic [3:0] CMD_SET_CONF       = 4'h1;
  localparam logic [3:0] CMD_SET_DIVISOR    = 4'h2;
  localparam logic [3:0] CMD_SET_USER_BYTE1 = 4'h3;

  localparam logic [7:0] DIVISOR_RST    = 8'd95;
  localparam logic [7:0] USER_BYTE1_RST = 8'd127;
  localparam logic [7:0] CONF_LF_ED     = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/lf_sync_edge.sv
// rtl/lf_sync_edge.sv - N-stage synchronizer with rise/fall pulses on the synchronized level
module lf_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic pck0,
  input  logic nreset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  // Top bit holds the previous synchronized sample for edge detection.
  logic [STAGES:0] sync;

  always_ff @(posedge pck0) begin
    if (!nreset) begin
      sync <= '1;
    end else begin
      sync <= {sync[STAGES-1:0], din};
    end
  end

  assign dout = sync[STAGES-1];
  assign rise = sync[STAGES-1] & ~sync[STAGES];
  assign fall = ~sync[STAGES-1] & sync[STAGES];

endmodule

// File: rtl/lf_spi_cmd_rx.sv
// rtl/lf_spi_cmd_rx.sv - SPI command frame receiver driving LF config registers; optional LF_CMD_READBACK_EN
module lf_spi_cmd_rx
  import lf_cmd_pkg::*;
#(
  parameter int WORD_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       pck0,
  input  logic       nreset,
  input  logic       spck,
  input  logic       mosi,
  input  logic       ncs,
  output logic       miso,
  output logic [7:0] conf_word,
  output logic [2:0] major_mode,
  output logic [7:0] divisor,
  output logic [7:0] user_byte1,
  output logic       cfg_strobe,
  output logic       frame_err
);

  localparam logic [4:0] WORD_CNT = 5'(WORD_BITS);

  logic spck_s, spck_rise, spck_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic ncs_s, ncs_rise, ncs_fall;

  lf_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_spck (
    .pck0(pck0), .nreset(nreset), .din(spck), .dout(spck_s), .rise(spck_rise), .fall(spck_fall)
  );
  lf_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .pck0(pck0), .nreset(nreset), .din(mosi), .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );
  lf_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ncs (
    .pck0(pck0), .nreset(nreset), .din(ncs), .dout(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
  );

  state_t               state, state_next;
  logic [WORD_BITS-1:0] sreg;
  logic [4:0]           bit_cnt;
  logic                 start;

  always_ff @(posedge pck0) begin
    if (!nreset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (!ncs_s) begin
          state_next = SHIFT;
          start      = 1'b1;
        end
      end
      SHIFT: begin
        if (ncs_rise) state_next = (bit_cnt == WORD_CNT) ? COMMIT : IDLE;
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pck0) begin
    if (!nreset) begin
      sreg       <= '0;
      bit_cnt    <= '0;
      conf_word  <= 8'h00;
      divisor    <= DIVISOR_RST;
      user_byte1 <= USER_BYTE1_RST;
      cfg_strobe <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cfg_strobe <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg    <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          // A chip-select release wins over a coincident clock edge.
          if (ncs_rise) begin
            frame_err <= (bit_cnt != WORD_CNT);
          end else if (spck_rise) begin
            sreg <= {sreg[WORD_BITS-2:0], mosi_s};
            if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        COMMIT: begin
          case (sreg[15:12])
            CMD_SET_CONF: begin
              conf_word  <= sreg[7:0];
              cfg_strobe <= 1'b1;
              if (sreg[7:0] == CONF_LF_ED) user_byte1 <= USER_BYTE1_RST;
            end
            CMD_SET_DIVISOR: begin
              divisor    <= sreg[7:0];
              cfg_strobe <= 1'b1;
            end
            CMD_SET_USER_BYTE1: begin
              user_byte1 <= sreg[7:0];
              cfg_strobe <= 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign major_mode = conf_word[7:5];

`ifdef LF_CMD_READBACK_EN
  logic [WORD_BITS-1:0] rb_word, rb_shift;
  logic                 miso_q;

  always_ff @(posedge pck0) begin
    if (!nreset) begin
      rb_word  <= '0;
      rb_shift <= '0;
      miso_q   <= 1'b0;
    end else begin
      if (state == COMMIT) rb_word <= sreg;
      if (start) begin
        miso_q   <= rb_word[WORD_BITS-1];
        rb_shift <= {rb_word[WORD_BITS-2:0], 1'b0};
      end else if (state == SHIFT && spck_fall && !ncs_rise) begin
        miso_q   <= rb_shift[WORD_BITS-1];
        rb_shift <= {rb_shift[WORD_BITS-2:0], 1'b0};
      end
    end
  end

  assign miso = miso_q;
`else
  assign miso = 1'b0;
`endif

  logic unused_edges;
  assign unused_edges = ^{mosi_rise, mosi_fall, ncs_fall, spck_fall, spck_s, sreg};

endmodule

// File: doc/lf_spi_cmd_rx.md
LF_SPI_CMD_RX -- requirements
Module: lf_spi_cmd_rx

Interface
REQ-001 SHALL have parameter WORD_BITS, default 16, meaning the number of bits in one SPI command frame.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on spck, mosi and ncs.
REQ-003 SHALL have port pck0, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port nreset, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port spck, input, 1 bit: asynchronous SPI clock from the MCU.
REQ-006 SHALL have port mosi, input, 1 bit: asynchronous SPI data, MSB first.
REQ-007 SHALL have port ncs, input, 1 bit: asynchronous SPI chip select, active-low.
REQ-008 SHALL have port miso, output, 1 bit: SPI readback data.
REQ-009 SHALL have port conf_word, output, 8 bits: configuration word.
REQ-010 SHALL have port major_mode, output, 3 bits: always equal to conf_word[7:5].
REQ-011 SHALL have port divisor, output, 8 bits: clock divisor for the downstream LF clock divider.
REQ-012 SHALL have port user_byte1, output, 8 bits: edge-detect threshold / user byte.
REQ-013 SHALL have port cfg_strobe, output, 1 bit: one-cycle pulse marking a register update.
REQ-014 SHALL have port frame_err, output, 1 bit: one-cycle pulse marking a rejected frame.

Function
REQ-015 SHALL synchronize spck, mosi and ncs through SYNC_STAGES flops each, then detect spck rise/fall and ncs rise from the synchronized samples.
REQ-016 SHALL implement states IDLE, SHIFT and COMMIT.
- IDLE -> SHIFT when ncs_s is 0; this clears the shift register and bit_cnt.
REQ-017 SHALL, in SHIFT, on each spck_s rise, shift mosi_s into the shift register LSB (left shift) and increment bit_cnt; bit_cnt is 5 bits and saturates at 31.
REQ-018 SHALL, in SHIFT, on ncs_s rise, go to COMMIT if bit_cnt == WORD_BITS; otherwise pulse frame_err for one cycle and return to IDLE.
REQ-019 SHALL, when an spck_s rise and an ncs_s rise are detected in the same cycle, discard the bit (ncs wins).
REQ-020 SHALL, in COMMIT (one cycle, then IDLE), decode word[15:12] as follows; updated outputs and cfg_strobe appear together on the cycle after COMMIT:
- 4'h1: conf_word <= word[7:0]; if word[7:0] == 8'h01, user_byte1 <= 8'd127 in the same cycle.
- 4'h2: divisor <= word[7:0].
- 4'h3: user_byte1 <= word[7:0].
- Any other opcode: no register change, no cfg_strobe, no frame_err.
REQ-021 SHALL have a latency of SYNC_STAGES+2 pck0 cycles from the ncs pin rise to the output update.
REQ-022 SHALL hold conf_word, divisor and user_byte1 stable between commits; a partial frame never alters them.

Reset
REQ-023 SHALL, with nreset low at a pck0 rise, force: state IDLE, shift register 0, bit_cnt 0, conf_word 8'h00, divisor 8'd95, user_byte1 8'd127, miso 0, cfg_strobe 0, frame_err 0, and all synchronizer flops to 1 (ncs/spck idle-high).
REQ-024 SHALL discard any in-flight frame when reset is asserted mid-frame; after release, the frame resumes only on ncs_s low, and bits are counted afresh (a truncated frame yields frame_err).

Configuration
REQ-025 SHALL support macro LF_CMD_READBACK_EN:
- Defined: miso shifts out the last committed 16-bit word MSB first, advancing on each spck_s fall while in SHIFT; the MSB is loaded on IDLE -> SHIFT.
- Undefined: miso is constant 0 and no readback register exists.

Structure
REQ-026 SHALL place in shared package lf_cmd_pkg: opcode constants (CMD_SET_CONF=1, CMD_SET_DIVISOR=2, CMD_SET_USER_BYTE1=3), reset defaults (95, 127), LF_ED conf value 8'h01, and the state enum.
REQ-027 SHALL use one sub-module lf_sync_edge (N-stage synchronizer plus rise/fall pulses), instantiated for spck, mosi and ncs.

Verification
REQ-028 SHALL cover: frame 16'h1001 -> conf_word=8'h01, user_byte1=127, major_mode=0, single cfg_strobe at ncs rise+SYNC_STAGES+2.
REQ-029 SHALL cover: frame 16'h2017 -> divisor=8'h17, conf_word unchanged, one cfg_strobe.
REQ-030 SHALL cover: frame 16'h3040 after 16'h1020 -> user_byte1=8'h40, major_mode=3'b001.
REQ-031 SHALL cover: 15-bit frame and 17-bit frame -> frame_err pulse each, no register change, no cfg_strobe.
REQ-032 SHALL cover: opcode 4'h7 frame -> no change and no pulses; nreset low mid-frame -> all outputs equal the REQ-023 values.
REQ-033 SHALL cover, with LF_CMD_READBACK_EN: commit 16'h2017, next frame -> miso bits 0010000000010111 on successive spck falls.
